mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port memory between instruction fetch (PC/ROM side) and data load/store (WriteBack side) of the CPU pipeline.
- Arbitrates between the two requesters with data-first priority and a starvation guard.
- Drives a req/ack memory port and returns per-requester completion with a timeout error path.

Parameters:
ADDR_W, 32, address width of both requesters and memory port
DATA_W, 32, data width; byte enables are DATA_W/8 wide
STARVE_LIMIT, 4, consecutive data grants taken while fetch waits before fetch is forced to win
TIMEOUT, 255, cycles in BUSY without m_ack before the transaction is aborted with error

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: fetch complete
if_rdata  out  DATA_W  fetch read data, valid with if_rvalid
if_rerr  out  1  fetch aborted by timeout, valid with if_rvalid
d_req  in  1  data request, held with d_we/d_addr/d_wdata/d_be until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  store byte enables
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: data op complete (loads and stores)
d_rdata  out  DATA_W  load data, valid with d_rvalid
d_rerr  out  1  data op aborted by timeout, valid with d_rvalid
m_req  out  1  memory request, held until m_ack or timeout
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_be  out  DATA_W/8  memory byte enables
m_ack  in  1  one-cycle memory completion strobe
m_rdata  in  DATA_W  memory read data, valid with m_ack

Behaviour:
- All outputs are registered.
- Reset (rst=0, async): state IDLE; all outputs 0; starve_cnt=0; timeout counter=0.
- Reset mid-transaction abandons it with no rvalid; memory must tolerate a dropped m_req.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, sampled at cycle N:
  - Winner = fetch if if_req && (!d_req || starve_cnt==STARVE_LIMIT); otherwise data if d_req.
  - At N+1: state BUSY_x, winner's gnt=1 for exactly one cycle, m_req=1, m_* latched.
  - Fetch latches m_we=0 and m_be=all ones.
  - Data latches d_we, d_addr, d_wdata, d_be verbatim.
  - No request: stay IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when data wins while if_req=1.
  - Clears to 0 when fetch wins.
  - Unchanged otherwise.
- BUSY_x:
  - m_* are held stable and the timeout counter increments each cycle.
  - m_ack=1 at cycle M: at M+1, x_rvalid=1, x_rdata=m_rdata (0 for stores), x_rerr=0, m_req=0, state IDLE, counter cleared.
  - Counter reaches TIMEOUT without m_ack: next cycle, m_req=0, x_rvalid=1, x_rerr=1, x_rdata=0, state IDLE.
- A new arbitration is evaluated in the IDLE cycle where rvalid is high. Best-case throughput is one transaction every 2 cycles (m_ack in the first BUSY cycle).
- The requester drops req the cycle after gnt unless issuing a new request. A req still high in the next IDLE cycle is treated as a new request.
- m_ack in IDLE is ignored and returns no rvalid.
- Requests arriving during BUSY wait; they are not queued beyond their held req.
- At most one transaction is outstanding. rvalid never pulses for both requesters in the same cycle.

Test Plan:
- Fetch only, addr 0x10, m_ack 2 cycles after m_req with m_rdata 0x00500093 -> if_gnt at N+1, m_addr 0x10, m_be 0xF, m_we 0; if_rvalid one cycle after ack with if_rdata 0x00500093, if_rerr 0.
- Store only, d_addr 0x200, d_wdata 0xDEADBEEF, d_be 0x3, immediate ack -> m_we 1, m_be 0x3, m_wdata 0xDEADBEEF; d_rvalid one cycle after ack; next request grantable 2 cycles after the prior grant.
- if_req and d_req both held continuously -> grant order D,D,D,D,I,D,D,D,D,I with STARVE_LIMIT=4; starve_cnt returns to 0 after each I grant.
- Load with m_ack never asserted, TIMEOUT=255 -> m_req drops after 255 BUSY cycles; d_rvalid=1, d_rerr=1, d_rdata=0; FSM back to IDLE and a subsequent fetch is served normally.
- rst pulled low in BUSY_D before ack -> all outputs 0 immediately (async); no d_rvalid after release; starve_cnt 0.
- Spurious m_ack in IDLE with no requests -> no rvalid, no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch vs data, data-first with starvation guard.
// Ports: clk/rst (async active-low), if_* fetch side, d_* data side, m_* memory.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rerr,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rerr,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  // Last BUSY cycle index before abort: BUSY lasts TIMEOUT cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;

  logic              if_gnt_q, if_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_rerr_q, if_rerr_d;
  logic              d_gnt_q, d_gnt_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_rerr_q, d_rerr_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]   m_be_q, m_be_d;

  logic pick_i;
  logic pick_d;
  logic tmo_hit;

  // Fetch only wins against data once it has been passed over enough times.
  assign pick_i  = if_req && (!d_req || (starve_q == STARVE_MAX));
  assign pick_d  = d_req && !pick_i;
  assign tmo_hit = (tmo_q == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_rerr_q   <= 1'b0;
      d_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_rerr_q    <= 1'b0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_be_q      <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_rerr_q   <= if_rerr_d;
      d_gnt_q     <= d_gnt_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_rerr_q    <= d_rerr_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_be_q      <= m_be_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    tmo_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d  = BUSY_I;
          starve_d = '0;
        end else if (pick_d) begin
          state_d = BUSY_D;
          if (if_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SC_W'(1);
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ack || tmo_hit) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = '0;
    if_rerr_d   = 1'b0;
    d_gnt_d     = 1'b0;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = '0;
    d_rerr_d    = 1'b0;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_be_d      = m_be_q;
    unique case (state_q)
      IDLE: begin
        m_req_d = 1'b0;
        if (pick_i) begin
          if_gnt_d  = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          m_be_d    = '1;
        end else if (pick_d) begin
          d_gnt_d   = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_be;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = m_rdata;
          m_req_d     = 1'b0;
        end else if (tmo_hit) begin
          if_rvalid_d = 1'b1;
          if_rerr_d   = 1'b1;
          m_req_d     = 1'b0;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          d_rvalid_d = 1'b1;
          // Stores complete with zero data; memory read bus is don't-care.
          d_rdata_d  = m_we_q ? '0 : m_rdata;
          m_req_d    = 1'b0;
        end else if (tmo_hit) begin
          d_rvalid_d = 1'b1;
          d_rerr_d   = 1'b1;
          m_req_d    = 1'b0;
        end
      end
      default: m_req_d = 1'b0;
    endcase
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_rerr   = if_rerr_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_rerr    = d_rerr_q;
  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_be      = m_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level memory and arbitration model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_rerr;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid, d_rerr;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;

  int errors = 0;
  int checks = 0;
  int ack_lat = 0;
  int mem_cnt = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_rerr(if_rerr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_rerr(d_rerr), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] w,
                                        logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [139:0] all_outs();
    return {if_gnt, if_rvalid, if_rdata, if_rerr, d_gnt, d_rvalid, d_rdata,
            d_rerr, m_req, m_we, m_addr, m_wdata, m_be};
  endfunction

  // Advance one clock, then act as the memory: ack after ack_lat
  // cycles of m_req (negative = never).
  task automatic step();
    @(posedge clk);
    #1;
    if (m_req === 1'b1) begin
      if (ack_lat >= 0 && mem_cnt == ack_lat) begin
        m_ack = 1'b1;
        if (m_we) begin
          mem[m_addr] = merge(mem_rd(m_addr), m_wdata, m_be);
          m_rdata = $urandom;
        end else begin
          m_rdata = mem_rd(m_addr);
        end
      end else begin
        m_ack = 1'b0;
      end
      mem_cnt++;
    end else begin
      m_ack = 1'b0;
      mem_cnt = 0;
      m_rdata = $urandom;
    end
  endtask

  task automatic collect_grants(input int n, output string seq);
    int cyc;
    seq = "";
    cyc = 0;
    while (seq.len() < n && cyc < n * 10) begin
      step();
      if (if_gnt) seq = {seq, "I"};
      if (d_gnt) seq = {seq, "D"};
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    m_ack = 0; m_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_outs() !== '0)
      $display("FAIL reset_outs: got %h want 0", all_outs());
    if (all_outs() !== '0) errors++;
    rst = 1'b1;
    step();
    checks++;
    if (m_req !== 1'b0 || if_gnt !== 1'b0 || d_gnt !== 1'b0) begin
      $display("FAIL reset_idle: m_req=%b if_gnt=%b d_gnt=%b want 0",
               m_req, if_gnt, d_gnt);
      errors++;
    end
  endtask

  task automatic test_fetch();
    int n;
    mem[32'h10] = 32'h00500093;
    ack_lat = 2;
    if_addr = 32'h10;
    if_req = 1'b1;
    step();
    checks++;
    if (if_gnt !== 1'b1 || m_req !== 1'b1 || m_addr !== 32'h10 ||
        m_be !== 4'hF || m_we !== 1'b0) begin
      $display("FAIL fetch_gnt: gnt=%b req=%b addr=%h be=%h we=%b want 1 1 10 f 0",
               if_gnt, m_req, m_addr, m_be, m_we);
      errors++;
    end
    if_req = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!if_rvalid && n < 10);
    checks++;
    if (n !== 3 || if_rdata !== 32'h00500093 || if_rerr !== 1'b0 ||
        d_rvalid !== 1'b0) begin
      $display("FAIL fetch_rvalid: lat=%0d data=%h err=%b drv=%b want 3 00500093 0 0",
               n, if_rdata, if_rerr, d_rvalid);
      errors++;
    end
    step();
    checks++;
    if (if_rvalid !== 1'b0 || m_req !== 1'b0) begin
      $display("FAIL fetch_pulse: rvalid=%b m_req=%b want 0 0", if_rvalid, m_req);
      errors++;
    end
  endtask

  task automatic test_store();
    logic [31:0] exp;
    exp = merge(init_word(32'h200), 32'hDEADBEEF, 4'h3);
    ack_lat = 0;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
    step();
    checks++;
    if (d_gnt !== 1'b1 || m_we !== 1'b1 || m_be !== 4'h3 ||
        m_wdata !== 32'hDEADBEEF || m_addr !== 32'h200) begin
      $display("FAIL store_gnt: gnt=%b we=%b be=%h wd=%h addr=%h want 1 1 3 deadbeef 200",
               d_gnt, m_we, m_be, m_wdata, m_addr);
      errors++;
    end
    d_req = 0;
    step();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_rerr !== 1'b0) begin
      $display("FAIL store_rvalid: rv=%b data=%h err=%b want 1 0 0",
               d_rvalid, d_rdata, d_rerr);
      errors++;
    end
    d_req = 1; d_we = 0;
    step();
    checks++;
    if (d_gnt !== 1'b1) begin
      $display("FAIL store_b2b_gnt: gnt=%b want 1", d_gnt);
      errors++;
    end
    d_req = 0;
    step();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== exp) begin
      $display("FAIL store_readback: rv=%b data=%h want 1 %h", d_rvalid, d_rdata, exp);
      errors++;
    end
  endtask

  task automatic test_starve();
    string seq;
    ack_lat = 0;
    if_addr = 32'h10; if_req = 1;
    d_addr = 32'h40; d_we = 0; d_req = 1;
    collect_grants(10, seq);
    checks++;
    if (seq != "DDDDIDDDDI") begin
      $display("FAIL starve_order: got %s want DDDDIDDDDI", seq);
      errors++;
    end
    if_req = 0; d_req = 0;
    repeat (3) step();
  endtask

  task automatic test_timeout();
    int n;
    ack_lat = -1;
    d_we = 0; d_addr = 32'h40; d_req = 1;
    step();
    checks++;
    if (d_gnt !== 1'b1) begin
      $display("FAIL timeout_gnt: gnt=%b want 1", d_gnt);
      errors++;
    end
    d_req = 0;
    n = 0;
    while (m_req === 1'b1 && n < 400) begin
      n++;
      step();
    end
    checks++;
    if (n !== 255) begin
      $display("FAIL timeout_len: busy cycles=%0d want 255", n);
      errors++;
    end
    checks++;
    if (d_rvalid !== 1'b1 || d_rerr !== 1'b1 || d_rdata !== 32'h0 ||
        if_rvalid !== 1'b0) begin
      $display("FAIL timeout_resp: rv=%b err=%b data=%h irv=%b want 1 1 0 0",
               d_rvalid, d_rerr, d_rdata, if_rvalid);
      errors++;
    end
    ack_lat = 1;
    if_addr = 32'h10; if_req = 1;
    step();
    checks++;
    if (if_gnt !== 1'b1) begin
      $display("FAIL timeout_next_gnt: gnt=%b want 1", if_gnt);
      errors++;
    end
    if_req = 0;
    n = 0;
    do begin
      step();
      n++;
    end while (!if_rvalid && n < 10);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093 || if_rerr !== 1'b0) begin
      $display("FAIL timeout_next_data: rv=%b data=%h err=%b want 1 00500093 0",
               if_rvalid, if_rdata, if_rerr);
      errors++;
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    bit bad;
    string seq;
    ack_lat = -1;
    if_addr = 32'h10; if_req = 1;
    d_addr = 32'h44; d_we = 0; d_req = 1;
    n = 0;
    do begin
      step();
      n++;
    end while (!d_gnt && n < 10);
    checks++;
    if (d_gnt !== 1'b1) begin
      $display("FAIL rstmid_gnt: gnt=%b want 1", d_gnt);
      errors++;
    end
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      $display("FAIL rstmid_async: got %h want 0", all_outs());
      errors++;
    end
    if_req = 0; d_req = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bad = 0;
    repeat (4) begin
      step();
      if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || m_req !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      $display("FAIL rstmid_quiet: rvalid or m_req seen after reset, want none");
      errors++;
    end
    ack_lat = 0;
    if_req = 1; d_req = 1;
    collect_grants(5, seq);
    checks++;
    if (seq != "DDDDI") begin
      $display("FAIL rstmid_starve: got %s want DDDDI", seq);
      errors++;
    end
    if_req = 0; d_req = 0;
    repeat (3) step();
  endtask

  task automatic test_spurious();
    int n;
    step();
    m_ack = 1'b1;
    m_rdata = 32'hFFFFFFFF;
    step();
    checks++;
    if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || m_req !== 1'b0 ||
        if_gnt !== 1'b0 || d_gnt !== 1'b0) begin
      $display("FAIL spurious_ack: irv=%b drv=%b req=%b want 0 0 0",
               if_rvalid, d_rvalid, m_req);
      errors++;
    end
    ack_lat = 0;
    if_addr = 32'h10; if_req = 1;
    step();
    checks++;
    if (if_gnt !== 1'b1) begin
      $display("FAIL spurious_next_gnt: gnt=%b want 1", if_gnt);
      errors++;
    end
    if_req = 0;
    n = 0;
    do begin
      step();
      n++;
    end while (!if_rvalid && n < 10);
    checks++;
    if (n !== 1 || if_rdata !== 32'h00500093) begin
      $display("FAIL spurious_next_data: lat=%0d data=%h want 1 00500093",
               n, if_rdata);
      errors++;
    end
    step();
  endtask

  task automatic test_random();
    bit busy, out_i, out_d, prev_i, prev_d, exp_i, cur_we;
    int starve;
    logic [31:0] exp_idata, exp_ddata;
    busy = 0; out_i = 0; out_d = 0; starve = 0;
    exp_idata = 0; exp_ddata = 0; cur_we = 0;
    ref_mem = mem;
    for (int cyc = 0; cyc < 600; cyc++) begin
      prev_i = if_req;
      prev_d = d_req;
      if (m_req !== 1'b1) ack_lat = $urandom_range(0, 3);
      step();
      checks++;
      if (!busy && (prev_i || prev_d)) begin
        exp_i = prev_i && (!prev_d || starve == 4);
        if (if_gnt !== exp_i || d_gnt !== !exp_i) begin
          $display("FAIL rand_arb: cyc=%0d ig=%b dg=%b want %b %b",
                   cyc, if_gnt, d_gnt, exp_i, !exp_i);
          errors++;
        end
        checks++;
        if (exp_i) begin
          if (m_addr !== if_addr || m_we !== 1'b0 || m_be !== 4'hF) begin
            $display("FAIL rand_mbus_i: addr=%h we=%b be=%h want %h 0 f",
                     m_addr, m_we, m_be, if_addr);
            errors++;
          end
          starve = 0;
          exp_idata = ref_rd(if_addr);
        end else begin
          if (m_addr !== d_addr || m_we !== d_we || m_be !== d_be ||
              m_wdata !== d_wdata) begin
            $display("FAIL rand_mbus_d: addr=%h we=%b be=%h wd=%h want %h %b %h %h",
                     m_addr, m_we, m_be, m_wdata, d_addr, d_we, d_be, d_wdata);
            errors++;
          end
          if (prev_i && starve < 4) starve++;
          cur_we = d_we;
          if (d_we) begin
            ref_mem[d_addr] = merge(ref_rd(d_addr), d_wdata, d_be);
            exp_ddata = 0;
          end else begin
            exp_ddata = ref_rd(d_addr);
          end
        end
        busy = 1;
      end else if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin
        $display("FAIL rand_nogrant: cyc=%0d ig=%b dg=%b want 0 0",
                 cyc, if_gnt, d_gnt);
        errors++;
      end
      if (if_gnt) begin if_req = 0; out_i = 1; end
      if (d_gnt) begin d_req = 0; out_d = 1; end
      if (if_rvalid || d_rvalid) begin
        checks++;
        if (if_rvalid && d_rvalid) begin
          $display("FAIL rand_dual_rvalid: cyc=%0d", cyc);
          errors++;
        end else if (if_rvalid) begin
          if (!out_i || if_rdata !== exp_idata || if_rerr !== 1'b0) begin
            $display("FAIL rand_irsp: out=%b data=%h err=%b want 1 %h 0",
                     out_i, if_rdata, if_rerr, exp_idata);
            errors++;
          end
          out_i = 0;
        end else begin
          if (!out_d || d_rdata !== exp_ddata || d_rerr !== 1'b0) begin
            $display("FAIL rand_drsp: out=%b we=%b data=%h err=%b want 1 %h 0",
                     out_d, cur_we, d_rdata, d_rerr, exp_ddata);
            errors++;
          end
          out_d = 0;
        end
        busy = 0;
      end
      if (cyc < 560) begin
        if (!if_req && !out_i && $urandom_range(0, 2) == 0) begin
          if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          if_req = 1;
        end
        if (!d_req && !out_d && $urandom_range(0, 2) == 0) begin
          d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          d_we = 1'($urandom_range(0, 1));
          d_wdata = $urandom;
          d_be = 4'($urandom_range(0, 15));
          d_req = 1;
        end
      end
    end
    checks++;
    if (out_i || out_d || busy) begin
      $display("FAIL rand_drain: outstanding i=%b d=%b busy=%b want 0", out_i, out_d, busy);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_starve();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
